// File: rtl/irig_b_encoder_if.sv
// irig_b_encoder_if: time load / run control and IRIG-B output bundle
interface irig_b_encoder_if;
  logic       enable;
  logic       load;
  logic [5:0] time_sec;
  logic [5:0] time_min;
  logic [4:0] time_hr;
  logic [8:0] time_day;
  logic       leap_year;
  logic       dout;
  logic       pps;
  logic       busy;
  logic [6:0] bit_index;
  modport master (
    output enable, load, time_sec, time_min, time_hr, time_day, leap_year,
    input  dout, pps, busy, bit_index
  );
  modport slave (
    input  enable, load, time_sec, time_min, time_hr, time_day, leap_year,
    output dout, pps, busy, bit_index
  );
endinterface

// File: rtl/irig_b_encoder.sv
// irig_b_encoder: IRIG-B00x DC-level-shift frame generator; define IRIG_SBS_EN to add the straight-binary seconds field
module irig_b_encoder #(
  parameter int TICKS_PER_MS = 100000
) (
  input logic              clk,
  input logic              rst,
  irig_b_encoder_if.slave  bus
);
  localparam int CELL = 10 * TICKS_PER_MS;
  localparam int CW = $clog2(CELL);
  localparam logic [CW-1:0] LAST = CW'(CELL - 1);
  localparam logic [CW-1:0] H2 = CW'(2 * TICKS_PER_MS);
  localparam logic [CW-1:0] H5 = CW'(5 * TICKS_PER_MS);
  localparam logic [CW-1:0] H8 = CW'(8 * TICKS_PER_MS);
  typedef enum logic {IDLE, SEND} state_t;
  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic [8:0] d;
  } tod_t;
  localparam tod_t TOD_RST = {6'd0, 6'd0, 5'd0, 9'd1};
  function automatic tod_t inc(tod_t t, logic leap);
    logic cs, cm, ch;
    cs = t.s >= 6'd59;
    cm = cs && t.m >= 6'd59;
    ch = cm && t.h >= 5'd23;
    inc.s = cs ? 6'd0 : t.s + 6'd1;
    inc.m = cs ? (cm ? 6'd0 : t.m + 6'd1) : t.m;
    inc.h = cm ? (ch ? 5'd0 : t.h + 5'd1) : t.h;
    inc.d = ch ? (t.d >= (leap ? 9'd366 : 9'd365) ? 9'd1 : t.d + 9'd1) : t.d;
  endfunction
  // Data bits of one frame; marker positions stay zero here and are forced by bit index.
  function automatic logic [99:0] enc(tod_t t);
    logic [99:0] f;
`ifdef IRIG_SBS_EN
    logic [16:0] sbs;
`endif
    f = '0;
    f[4:1]   = 4'(t.s % 6'd10);
    f[8:6]   = 3'(t.s / 6'd10);
    f[13:10] = 4'(t.m % 6'd10);
    f[17:15] = 3'(t.m / 6'd10);
    f[23:20] = 4'(t.h % 5'd10);
    f[26:25] = 2'(t.h / 5'd10);
    f[33:30] = 4'(t.d % 9'd10);
    f[38:35] = 4'((t.d / 9'd10) % 9'd10);
    f[41:40] = 2'(t.d / 9'd100);
`ifdef IRIG_SBS_EN
    sbs = 17'(t.h) * 17'd3600 + 17'(t.m) * 17'd60 + 17'(t.s);
    f[88:80] = sbs[8:0];
    f[97:90] = sbs[16:9];
`endif
    return f;
  endfunction
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]  bit_q, bit_d;
  tod_t        cur_q, cur_d, ld_q, ld_d, nxt;
  logic        pend_q, pend_d;
  logic [99:0] frame_q, frame_d;
  logic        dout_q, dout_d, pps_q, pps_d, busy_q, busy_d;
  logic        end_cell, frame_end, entry, mk;
  logic [CW-1:0] hi;
  // Cell timing, frame sequencing, time update at frame boundaries and output shaping.
  always_comb begin
    end_cell = cnt_q == LAST;
    frame_end = state_q == SEND && end_cell && bit_q == 7'd99;
    entry = bus.enable && (state_q == IDLE || frame_end);
    state_d = state_q == IDLE ? (bus.enable ? SEND : IDLE) : (frame_end && !bus.enable ? IDLE : SEND);
    cnt_d = (state_q == SEND && state_d == SEND && !end_cell) ? cnt_q + CW'(1) : '0;
    bit_d = (state_q == SEND && state_d == SEND) ? (end_cell ? (frame_end ? 7'd0 : bit_q + 7'd1) : bit_q) : 7'd0;
    nxt = pend_q ? ld_q : (frame_end ? inc(cur_q, bus.leap_year) : cur_q);
    cur_d = (frame_end || entry) ? nxt : cur_q;
    pend_d = bus.load || (pend_q && !(frame_end || entry));
    ld_d = bus.load ? {bus.time_sec, bus.time_min, bus.time_hr, bus.time_day} : ld_q;
    frame_d = entry ? enc(nxt) : frame_q;
    mk = bit_d == 7'd0 || bit_d % 7'd10 == 7'd9;
    hi = mk ? H8 : (frame_q[bit_d] ? H5 : H2);
    dout_d = state_d == SEND && cnt_d < hi;
    pps_d = entry;
    busy_d = state_d == SEND;
  end
  // State and output registers; reset returns to IDLE with time 00:00:00 day 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      cur_q <= TOD_RST;
      ld_q <= TOD_RST;
      pend_q <= 1'b0;
      frame_q <= '0;
      dout_q <= 1'b0;
      pps_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      cur_q <= cur_d;
      ld_q <= ld_d;
      pend_q <= pend_d;
      frame_q <= frame_d;
      dout_q <= dout_d;
      pps_q <= pps_d;
      busy_q <= busy_d;
    end
  end
  assign bus.dout = dout_q;
  assign bus.pps = pps_q;
  assign bus.busy = busy_q;
  assign bus.bit_index = bit_q;
endmodule

// File: tb/tb_irig_b_encoder.sv
// tb_irig_b_encoder: directed table-driven bench for irig_b_encoder at TICKS_PER_MS=4
module tb_irig_b_encoder;
  localparam int T = 4;
  localparam int CELL = 10 * T;
  localparam int FR = 100 * CELL;
  localparam bit SBS =
`ifdef IRIG_SBS_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  irig_b_encoder_if bus();
  irig_b_encoder #(.TICKS_PER_MS(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    int  s, m, h, d;
    bit  leap;
    int  e1, e2, sbs;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic bit is_mk(int b);
    return b == 0 || b % 10 == 9;
  endfunction
  function automatic bit is_data(int b);
    return (b >= 1 && b <= 4) || (b >= 6 && b <= 8) || (b >= 10 && b <= 13) || (b >= 15 && b <= 17) ||
           (b >= 20 && b <= 23) || (b >= 25 && b <= 26) || (b >= 30 && b <= 33) || (b >= 35 && b <= 38) ||
           (b >= 40 && b <= 41) || (SBS && ((b >= 80 && b <= 88) || (b >= 90 && b <= 97)));
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic load_time(input int s, input int m, input int h, input int d);
    bus.time_sec = 6'(s);
    bus.time_min = 6'(m);
    bus.time_hr = 5'(h);
    bus.time_day = 9'(d);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic wait_bit(input int n);
    bit got = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk);
      got = bus.busy && bus.bit_index == 7'(n);
    end
    if (!got) chk("wait_bit_timeout", n, -1);
  endtask
  // Waits for pps, measures every cell's high time and decodes the frame as DDDHHMMSS plus SBS.
  task automatic capture(output int tod, output int sbs, output int bad, output int ppsn);
    int w[100];
    bit v[100];
    bit got;
    int s, m, h, d;
    tod = -1; sbs = -1; bad = -1; ppsn = -1; got = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk);
      got = bus.pps;
    end
    if (!got) begin
      chk("pps_timeout", 0, 1);
      return;
    end
    bad = 0; ppsn = 0;
    for (int b = 0; b < 100; b++) w[b] = 0;
    for (int k = 0; k < FR; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.dout) w[k / CELL]++;
      ppsn += int'(bus.pps);
      if (bus.bit_index != 7'(k / CELL) || !bus.busy) bad++;
      if (k % CELL == 0 && !bus.dout) bad++;
    end
    for (int b = 0; b < 100; b++) begin
      v[b] = w[b] == 5 * T;
      if (is_mk(b) ? w[b] != 8 * T : !(w[b] == 2 * T || (w[b] == 5 * T && is_data(b)))) bad++;
    end
    s = v[1] + 2 * v[2] + 4 * v[3] + 8 * v[4] + 10 * (v[6] + 2 * v[7] + 4 * v[8]);
    m = v[10] + 2 * v[11] + 4 * v[12] + 8 * v[13] + 10 * (v[15] + 2 * v[16] + 4 * v[17]);
    h = v[20] + 2 * v[21] + 4 * v[22] + 8 * v[23] + 10 * (v[25] + 2 * v[26]);
    d = v[30] + 2 * v[31] + 4 * v[32] + 8 * v[33] + 10 * (v[35] + 2 * v[36] + 4 * v[37] + 8 * v[38]) +
        100 * (v[40] + 2 * v[41]);
    tod = d * 1000000 + h * 10000 + m * 100 + s;
    sbs = 0;
    for (int i = 0; i < 9; i++) sbs += int'(v[80 + i]) << i;
    for (int i = 0; i < 8; i++) sbs += int'(v[90 + i]) << (9 + i);
  endtask
  initial begin
    int tod, sbs, bad, ppsn, n, hits;
    vecs[0] = '{56, 34, 12, 123, 1'b0, 123123456, 123123457, 45296};
    vecs[1] = '{59, 59, 23, 365, 1'b0, 365235959, 1000000, 86399};
    vecs[2] = '{59, 59, 23, 365, 1'b1, 365235959, 366000000, 86399};
    vecs[3] = '{59, 59, 23, 366, 1'b1, 366235959, 1000000, 86399};
    vecs[4] = '{1, 0, 1, 1, 1'b0, 1010001, 1010002, 3601};
    bus.enable = 1'b0; bus.load = 1'b0; bus.leap_year = 1'b0;
    bus.time_sec = '0; bus.time_min = '0; bus.time_hr = '0; bus.time_day = '0;
    rst = 1'b1;
    #12;
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_pps", int'(bus.pps), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_bit_index", int'(bus.bit_index), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      bus.leap_year = vecs[i].leap;
      load_time(vecs[i].s, vecs[i].m, vecs[i].h, vecs[i].d);
      bus.enable = 1'b1;
      capture(tod, sbs, bad, ppsn);
      chk($sformatf("v%0d_f1_time", i), tod, vecs[i].e1);
      chk($sformatf("v%0d_f1_sbs", i), sbs, SBS ? vecs[i].sbs : 0);
      chk($sformatf("v%0d_f1_format", i), bad, 0);
      chk($sformatf("v%0d_f1_pps_count", i), ppsn, 1);
      capture(tod, sbs, bad, ppsn);
      chk($sformatf("v%0d_f2_time", i), tod, vecs[i].e2);
      chk($sformatf("v%0d_f2_format", i), bad, 0);
    end
    do_reset();
    bus.leap_year = 1'b0;
    load_time(56, 34, 12, 123);
    bus.enable = 1'b1;
    wait_bit(37);
    chk("mid_pre_rst_dout", int'(bus.dout), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", int'(bus.dout), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_bit_index", int'(bus.bit_index), 0);
    @(negedge clk);
    rst = 1'b0;
    capture(tod, sbs, bad, ppsn);
    chk("after_rst_time", tod, 1000000);
    chk("after_rst_format", bad, 0);
    do_reset();
    load_time(30, 20, 10, 50);
    bus.enable = 1'b1;
    fork
      capture(tod, sbs, bad, ppsn);
      begin
        wait_bit(50);
        load_time(3, 2, 1, 7);
        wait_bit(60);
        load_time(7, 6, 5, 200);
      end
    join
    chk("midload_f1_time", tod, 50102030);
    chk("midload_f1_format", bad, 0);
    capture(tod, sbs, bad, ppsn);
    chk("midload_f2_time", tod, 200050607);
    capture(tod, sbs, bad, ppsn);
    chk("midload_f3_time", tod, 200050608);
    do_reset();
    bus.enable = 1'b1;
    hits = 0;
    for (int i = 0; i < 100 && !bus.pps; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 6000; i++) begin
      if (!bus.busy) break;
      n++;
      if (bus.bit_index == 7'd10) bus.enable = 1'b0;
      @(negedge clk);
    end
    chk("drop_busy_cycles", n, FR);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hits += int'(bus.dout) + int'(bus.busy) + int'(bus.pps);
    end
    chk("drop_idle_quiet", hits, 0);
    @(posedge clk);
    #1 bus.enable = 1'b1;
    @(posedge clk);
    #1;
    chk("reenable_pps", int'(bus.pps), 1);
    chk("reenable_dout", int'(bus.dout), 1);
    chk("reenable_busy", int'(bus.busy), 1);
    @(posedge clk);
    #1;
    chk("reenable_pps_one_cycle", int'(bus.pps), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irig_b_encoder.md
# irig_b_encoder

Generates an IRIG-B00x DC-level-shift time code frame from a loaded time of day and advances that time itself once per frame. It is the transmit side of the IRIG-B decoder chain. The block either drives a GPS-less timing output or acts as a loopback stimulus source for the decoder. Bits are pulse-width coded: zero = 2 ms high, one = 5 ms high, marker = 8 ms high, within a 10 ms bit cell, 100 bits per 1 s frame.

## Interface
- TICKS_PER_MS, default 100000 — clk cycles per millisecond; bit cell = 10*TICKS_PER_MS cycles.
- clk  in  1 — single clock.
- rst  in  1 — asynchronous, active-high reset.
- enable  in  1 — run request; sampled only at frame boundaries.
- load  in  1 — one-cycle strobe; captures the time_* inputs.
- time_sec  in  6 — binary 0–59.
- time_min  in  6 — binary 0–59.
- time_hr  in  5 — binary 0–23.
- time_day  in  9 — binary 1–366.
- leap_year  in  1 — day wraps after 366 when 1, after 365 when 0.
- dout  out  1 — IRIG-B DC-level output.
- pps  out  1 — one-cycle pulse on the first cycle of bit 0, the on-time point.
- busy  out  1 — high while a frame is transmitting.
- bit_index  out  7 — index of the current bit, 0–99.

## Operation
- Reset values:
  - dout=0, pps=0, busy=0, bit_index=0.
  - Time registers = 00:00:00, day 1. No load pending.
- States:
  - IDLE: dout=0. Moves to SEND when enable=1.
  - SEND: transmits bits 0–99. After bit 99 ends it returns to SEND (next frame) if enable=1, otherwise to IDLE.
- Frame shadow:
  - At entry to bit 0, the current time is converted to BCD and latched into a frame shadow.
  - The frame encodes only the shadow, so mid-frame loads and increments never corrupt the frame being sent.
- Time update, at the end of bit 99 (and at the IDLE→SEND transition):
  - If a load is pending, the loaded value becomes the current time and is not incremented. The pending flag clears.
  - Otherwise, after any frame ends, the current time increments by 1 s with carries: sec 59→0 increments min; min 59→0 increments hr; hr 23→0 increments day; day 365→1, or 366→1 when leap_year=1.
  - A load strobe in any state sets pending. A later load before the boundary overwrites the earlier one.
- Frame layout (BCD, LSB first):
  - Markers at bits 0 (Pr), 9, 19, …, 99. Bits 99 and 0 form the two consecutive markers.
  - Bits 1–4: sec units; 6–8: sec tens.
  - Bits 10–13: min units; 15–17: min tens.
  - Bits 20–23: hr units; 25–26: hr tens.
  - Bits 30–33: day units; 35–38: day tens; 40–41: day hundreds.
  - All other non-marker bits are zero unless IRIG_SBS_EN applies.
- Out-of-range time inputs are loaded unchecked. Increment continues from the wrapped comparison: any sec ≥59 wraps to 0.

## Timing
- dout rises on the first cycle of each bit cell. It stays high for 2/5/8*TICKS_PER_MS cycles, then is low for the rest of the cell.
- The first bit 0 starts the cycle after enable is sampled high in IDLE.
- pps is coincident with the rising dout of bit 0. bit_index updates on the same cycle as that bit's rising dout.
- dout, pps and bit_index are registered outputs.
- enable deasserted mid-frame: the frame completes to the end of bit 99, then the block goes to IDLE.
- rst mid-frame: all outputs return to reset values immediately (asynchronous). Operation restarts from IDLE.

## Configuration
- IRIG_SBS_EN defined: straight-binary seconds-of-day (0–86399, computed from the shadow time) is encoded LSB first.
  - SBS bits 0–8 go in frame bits 80–88.
  - SBS bits 9–16 go in frame bits 90–97.
  - This is the B000/B004 SBS field.
- IRIG_SBS_EN undefined: bits 80–88 and 90–97 are zeros (B002 behaviour) and the SBS multiplier logic is absent.

## Test plan
- Reset mid-frame, with TICKS_PER_MS=4: assert rst at bit 37 -> dout=0, busy=0, bit_index=0 on the same cycle; next frame after release encodes 00:00:00 day 1.
- Load 12:34:56 day 123, then enable -> pps once.
  - Bit 0 high 32 cycles; bits 1–4 high 8,20,20,8 cycles (units 6).
  - Bits 6–8 high 20,8,20 cycles (tens 5); bits 20–23 high 8,20,8,8 cycles (hr units 2); bits 40–41 high 20,8 cycles (day hundreds 1).
- Rollover: load 23:59:59 day 365 with leap_year=0 -> second frame encodes 00:00:00 day 1. Same with leap_year=1 -> day 366.
- Load at bit 50 of a frame -> current frame unchanged; next frame carries the loaded time, not the loaded time plus 1 s.
- Drop enable at bit 10 -> frame completes through bit 99, then dout stays 0 and busy=0. Re-enable -> pps one cycle later.
- With IRIG_SBS_EN, load 01:00:01 -> SBS 3601 (0b111000010001): bits 80, 84, 89 marker, 90, 91, 92 high for 5 ms; other SBS bits 2 ms.
